// File: rtl/btn_event_gen.sv
// btn_event_gen: synchronises, debounces and press-edge detects three active-low buttons into one-cycle pulses.
// Optional feature macro: BTN_AUTOREPEAT_EN enables held inc/dec auto-repeat.
module btn_event_gen #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_increment_n,
  input  logic       btn_decrement_n,
  input  logic       btn_reset_n,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       rst_pulse,
  output logic [2:0] btn_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(RMAX + 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1
  } state_t;
`endif

  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_DELAY < 1) begin : g_cfg_err
    $error("btn_event_gen: illegal parameter value");
  end

  // Bit order everywhere: [0]=inc, [1]=dec, [2]=reset.
  logic [2:0]    w_raw_n;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_acc;
  logic [2:0]    r_level;
  logic [CW-1:0] r_cnt [3];
  logic [2:0]    w_fire;
  logic          w_inc;
  logic          w_dec;
  logic          w_rst;
  logic          r_inc_pulse;
  logic          r_dec_pulse;
  logic          r_rst_pulse;

  assign w_raw_n = {btn_reset_n, btn_decrement_n, btn_increment_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
      r_acc   <= 3'b000;
      r_level <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= {CW{1'b0}};
      end
    end else begin
      r_sync1 <= w_raw_n;
      r_sync2 <= r_sync1;
      r_level <= r_acc;
      for (int i = 0; i < 3; i++) begin
        if (~r_sync2[i] == r_acc[i]) begin
          r_cnt[i] <= {CW{1'b0}};
        end else if (r_cnt[i] == CNT_LAST) begin
          r_cnt[i] <= {CW{1'b0}};
          r_acc[i] <= ~r_acc[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Per-button FSM runs off the registered level, giving the extra pipeline stage before the pulse.
  for (genvar g = 0; g < 3; g++) begin : g_btn
    state_t r_state;
    state_t w_state_nxt;
    logic   w_fire_b;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit CAN_REPEAT = (g != 2);
    localparam int OTHER      = (g == 0) ? 1 : 0;
    logic [TW-1:0] r_tmr;
    logic          w_wrap;
    logic          w_quiet;

    assign w_quiet = ~r_level[OTHER];

    always_comb begin
      w_wrap = 1'b0;
      if (r_state == ST_PRESS) begin
        w_wrap = (r_tmr == DELAY_LAST);
      end else if (r_state == ST_REPEAT) begin
        w_wrap = (r_tmr == PERIOD_LAST);
      end else begin
        w_wrap = 1'b0;
      end
    end

    // Timer keeps running while the opposite button is held; only the pulse is masked.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_tmr <= {TW{1'b0}};
      end else if (r_state == ST_IDLE || w_wrap) begin
        r_tmr <= {TW{1'b0}};
      end else begin
        r_tmr <= r_tmr + TW'(1);
      end
    end
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= ST_IDLE;
      end else begin
        r_state <= w_state_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_fire_b    = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_level[g]) begin
            w_state_nxt = ST_PRESS;
            w_fire_b    = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_PRESS: begin
          if (!r_level[g]) begin
            w_state_nxt = ST_IDLE;
`ifdef BTN_AUTOREPEAT_EN
          end else if (CAN_REPEAT && w_wrap) begin
            w_state_nxt = ST_REPEAT;
            w_fire_b    = w_quiet;
`endif
          end else begin
            w_state_nxt = ST_PRESS;
          end
        end
`ifdef BTN_AUTOREPEAT_EN
        ST_REPEAT: begin
          if (!r_level[g]) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_REPEAT;
            w_fire_b    = w_wrap & w_quiet;
          end
        end
`endif
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    assign w_fire[g] = w_fire_b;
  end

  // Reset event dominates; simultaneous inc and dec cancel.
  always_comb begin
    w_rst = w_fire[2];
    if (w_fire[2]) begin
      w_inc = 1'b0;
      w_dec = 1'b0;
    end else begin
      w_inc = w_fire[0] & ~w_fire[1];
      w_dec = w_fire[1] & ~w_fire[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inc_pulse <= 1'b0;
      r_dec_pulse <= 1'b0;
      r_rst_pulse <= 1'b0;
    end else begin
      r_inc_pulse <= w_inc;
      r_dec_pulse <= w_dec;
      r_rst_pulse <= w_rst;
    end
  end

  assign inc_pulse = r_inc_pulse;
  assign dec_pulse = r_dec_pulse;
  assign rst_pulse = r_rst_pulse;
  assign btn_level = r_level;

endmodule

// File: tb/tb_btn_event_gen.sv
// Randomised and directed bench for btn_event_gen against a sample-window reference model.
module tb_btn_event_gen;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int N  = 8192;
`ifdef BTN_AUTOREPEAT_EN
  localparam int EXP_T2 = 5;
  localparam int EXP_T5 = 8;
`else
  localparam int EXP_T2 = 1;
  localparam int EXP_T5 = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       bi, bd, br;
  logic       ip, dp, rp;
  logic [2:0] lvl;

  btn_event_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst),
    .btn_increment_n(bi), .btn_decrement_n(bd), .btn_reset_n(br),
    .inc_pulse(ip), .dec_pulse(dp), .rst_pulse(rp), .btn_level(lvl)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model: per-edge history of pressed samples; a level flips once the
  // D samples taken 2..D+1 edges earlier all disagree with it.
  bit smp [3][N];
  bit acc [3][N];
  bit lv  [3][N];
  int ge = 8;
  int pstart [3] = '{-1, -1, -1};
  bit e_inc, e_dec, e_rst;
  bit [2:0] e_lvl;

  task automatic model_edge(input bit [2:0] pr, input bit r);
    bit cand [3];
    bit flip;
    int d;
    ge++;
    for (int b = 0; b < 3; b++) begin
      cand[b] = 1'b0;
      if (r) begin
        smp[b][ge] = 1'b0;
        smp[b][ge-1] = 1'b0;
        acc[b][ge] = 1'b0;
        lv[b][ge] = 1'b0;
      end else begin
        smp[b][ge] = pr[b];
        flip = 1'b1;
        for (int j = ge - D - 1; j <= ge - 2; j++) begin
          if (smp[b][j] == acc[b][ge-1]) flip = 1'b0;
        end
        acc[b][ge] = flip ? !acc[b][ge-1] : acc[b][ge-1];
        lv[b][ge] = acc[b][ge-1];
      end
    end
    for (int b = 0; b < 3; b++) begin
      if (!r) begin
        if (lv[b][ge-1] && !lv[b][ge-2]) begin
          cand[b] = 1'b1;
          pstart[b] = ge;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (b < 2 && pstart[b] >= 0 && lv[b][ge-1]) begin
          d = ge - pstart[b];
          if (d >= RD && ((d - RD) % RP) == 0 && !lv[1-b][ge-1]) cand[b] = 1'b1;
        end
`endif
      end
      if (r || !lv[b][ge]) pstart[b] = -1;
    end
    e_rst = cand[2];
    e_inc = cand[0] && !cand[1] && !cand[2];
    e_dec = cand[1] && !cand[0] && !cand[2];
    e_lvl = {lv[2][ge], lv[1][ge], lv[0][ge]};
  endtask

  int edge_rel, n_inc, n_dec, n_rst, first_inc, second_inc, first_lvl0;
  logic [63:0] inc_seen, rst_seen;
  logic [2:0]  lvl_or;

  task automatic mark();
    edge_rel = -1; n_inc = 0; n_dec = 0; n_rst = 0;
    first_inc = -1; second_inc = -1; first_lvl0 = -1;
    inc_seen = 64'd0; rst_seen = 64'd0; lvl_or = 3'b000;
  endtask

  task automatic step(input logic [2:0] raw_n, input logic r);
    {br, bd, bi} = raw_n;
    rst = r;
    @(posedge clk);
    model_edge(~raw_n, r);
    edge_rel++;
    @(negedge clk);
    check_eq("inc_pulse", {31'd0, ip}, {31'd0, e_inc});
    check_eq("dec_pulse", {31'd0, dp}, {31'd0, e_dec});
    check_eq("rst_pulse", {31'd0, rp}, {31'd0, e_rst});
    check_eq("btn_level", {29'd0, lvl}, {29'd0, e_lvl});
    lvl_or = lvl_or | lvl;
    if (lvl[0] === 1'b1 && first_lvl0 < 0) first_lvl0 = edge_rel;
    if (ip === 1'b1) begin
      n_inc++;
      if (first_inc < 0) first_inc = edge_rel;
      else if (second_inc < 0) second_inc = edge_rel;
      if (edge_rel < 64) inc_seen[edge_rel] = 1'b1;
    end
    if (dp === 1'b1) n_dec++;
    if (rp === 1'b1) begin
      n_rst++;
      if (edge_rel < 64) rst_seen[edge_rel] = 1'b1;
    end
  endtask

  task automatic hold(input logic [2:0] raw_n, input logic r, input int n);
    for (int i = 0; i < n; i++) step(raw_n, r);
  endtask

  logic [2:0] cur_n;
  int rem [3];
  int rrem;

  initial begin
    mark();
    // Reset with every button pressed, then only inc stays held.
    hold(3'b000, 1'b1, 2);
    check_eq("reset_outputs", {26'd0, ip, dp, rp, lvl}, 32'd0);
    mark();
    hold(3'b110, 1'b0, 20);
    check_eq("t1_first_inc", first_inc, 32'd7);
    check_eq("t1_no_rst", n_rst, 32'd0);
    hold(3'b111, 1'b0, 15);

    // Clean press.
    mark();
    hold(3'b110, 1'b0, 20);
    hold(3'b111, 1'b0, 12);
    check_eq("t2_first_inc", first_inc, 32'd7);
    check_eq("t2_lvl_edge", first_lvl0, 32'd6);
    check_eq("t2_inc_count", n_inc, EXP_T2);

    // Bounce shorter than the debounce window.
    mark();
    hold(3'b101, 1'b0, 3);
    hold(3'b111, 1'b0, 1);
    hold(3'b101, 1'b0, 3);
    hold(3'b111, 1'b0, 10);
    check_eq("t3_no_dec", n_dec, 32'd0);
    check_eq("t3_level", {29'd0, lvl_or}, 32'd0);

    // inc with reset: reset wins.
    mark();
    hold(3'b010, 1'b0, 12);
    hold(3'b111, 1'b0, 12);
    check_eq("t4_rst_at7", {31'd0, rst_seen[7]}, 32'd1);
    check_eq("t4_inc_at7", {31'd0, inc_seen[7]}, 32'd0);

    // inc with dec: cancel.
    mark();
    hold(3'b100, 1'b0, 12);
    hold(3'b111, 1'b0, 12);
    check_eq("t4_cancel", n_inc + n_dec, 32'd0);

    // Long hold.
    mark();
    hold(3'b110, 1'b0, 30);
    hold(3'b111, 1'b0, 12);
    check_eq("t5_inc_count", n_inc, EXP_T5);
`ifdef BTN_AUTOREPEAT_EN
    check_eq("t5_second_inc", second_inc, 32'd17);
    check_eq("t5_inc_at20", {31'd0, inc_seen[20]}, 32'd1);
    check_eq("t5_inc_at23", {31'd0, inc_seen[23]}, 32'd1);
`endif

    // Reset while inc is held.
    hold(3'b110, 1'b0, 20);
    hold(3'b110, 1'b1, 2);
    mark();
    hold(3'b110, 1'b0, 12);
    check_eq("t6_first_inc", first_inc, 32'd7);
    hold(3'b111, 1'b0, 15);

    // Random button activity with occasional resets.
    cur_n = 3'b111;
    rem = '{0, 0, 0};
    rrem = 0;
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          if ($urandom_range(0, 3) == 0) rem[b] = int'($urandom_range(1, 3));
          else rem[b] = int'($urandom_range(4, 40));
          cur_n[b] = ($urandom_range(0, 1) == 1);
        end
        rem[b]--;
      end
      if (rrem == 0 && $urandom_range(0, 199) == 0) rrem = int'($urandom_range(1, 3));
      step(cur_n, rrem > 0);
      if (rrem > 0) rrem--;
    end
    hold(3'b111, 1'b0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
